raster_compositor: RTL and testbench

//   Requester side of the layer pixel-request interface. Walks the VGA raster and

---
 rtl/raster_compositor_pkg.sv | 36 +++
 rtl/raster_compositor_if.sv | 27 ++
 rtl/raster_compositor_timing.sv | 65 ++++++
 rtl/raster_compositor.sv | 111 +++++++++++
 tb/tb_raster_compositor.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/raster_compositor_pkg.sv
// Shared colour codes, pipeline flag bundle
// and the layer merge rule for the raster compositor.
package raster_compositor_pkg;

  localparam int COLOR_WIDTH = 4;

  localparam logic [COLOR_WIDTH-1:0] COLOR_BLACK = 4'h0;
  localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE  = 4'h1;
  localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 4'h4;
  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 4'hf;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic first;
    logic strobe;
  } flags_t;

  function automatic logic [COLOR_WIDTH-1:0] merge(
    input logic                   active,
    input logic [COLOR_WIDTH-1:0] cursor,
    input logic [COLOR_WIDTH-1:0] canvas
  );
    logic [COLOR_WIDTH-1:0] c;
    c = COLOR_BLACK;
    if (active) begin
      if (cursor != COLOR_NONE)
        c = cursor;
      else if (canvas != COLOR_NONE)
        c = canvas;
    end
    return c;
  endfunction

endpackage

// File: rtl/raster_compositor_if.sv
// Layer pixel-request bus: the compositor issues x/y,
// the cursor and canvas layers answer one clock later.
interface raster_compositor_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  import raster_compositor_pkg::*;

  logic [XW-1:0]          request_x;
  logic [YW-1:0]          request_y;
  logic [COLOR_WIDTH-1:0] cursor_color;
  logic [COLOR_WIDTH-1:0] canvas_color;

  modport master (
    output request_x,
    output request_y,
    input  cursor_color,
    input  canvas_color
  );

  modport slave (
    input  request_x,
    input  request_y,
    output cursor_color,
    output canvas_color
  );
endinterface

// File: rtl/raster_compositor_timing.sv
// VGA raster walker: h/v counters with wrap, plus
// visible/sync/first flags and in-range coordinates.
module vga_timing_counter #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  output logic [XW-1:0] col,
  output logic [YW-1:0] row,
  output logic          active,
  output logic          hs,
  output logic          vs,
  output logic          first
);

  localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT  = HW'(WIDTH);
  localparam logic [HW-1:0] H_SS   = HW'(WIDTH + H_FRONT);
  localparam logic [HW-1:0] H_SE   = HW'(WIDTH + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(HEIGHT);
  localparam logic [VW-1:0] V_SS   = VW'(HEIGHT + V_FRONT);
  localparam logic [VW-1:0] V_SE   = VW'(HEIGHT + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v;

  // raster position, one pixel per strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + VW'(1);
      end else begin
        h <= h + HW'(1);
      end
    end
  end

  assign active = (h < H_ACT) && (v < V_ACT);
  assign hs     = (h >= H_SS) && (h < H_SE);
  assign vs     = (v >= V_SS) && (v < V_SE);
  assign first  = (h == '0) && (v == '0);
  assign col    = active ? h[XW-1:0] : '0;
  assign row    = active ? v[YW-1:0] : '0;

endmodule

// File: rtl/raster_compositor.sv
// Raster compositor top: issues layer requests,
// delays flags to match layer latency, merges colours.
module raster_compositor
  import raster_compositor_pkg::*;
#(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_en,
  raster_compositor_if.master    layer,
  output logic [COLOR_WIDTH-1:0] pixel_color,
  output logic                   pixel_active,
  output logic                   hsync_n,
  output logic                   vsync_n,
  output logic                   frame_start
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic          active;
  logic          hs;
  logic          vs;
  logic          first;

  logic [XW-1:0] req_x;
  logic [YW-1:0] req_y;
  flags_t        s0;
  flags_t        s1;

  vga_timing_counter #(
    .WIDTH   (WIDTH),
    .HEIGHT  (HEIGHT),
    .H_FRONT (H_FRONT),
    .H_SYNC  (H_SYNC),
    .H_BACK  (H_BACK),
    .V_FRONT (V_FRONT),
    .V_SYNC  (V_SYNC),
    .V_BACK  (V_BACK)
  ) u_timing (
    .clk    (clk),
    .reset  (reset),
    .pix_en (pix_en),
    .col    (col),
    .row    (row),
    .active (active),
    .hs     (hs),
    .vs     (vs),
    .first  (first)
  );

  assign layer.request_x = req_x;
  assign layer.request_y = req_y;

  // stage 0: request and flags captured on each strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      req_x <= '0;
      req_y <= '0;
      s0    <= '0;
    end else begin
      s0.strobe <= pix_en;
      if (pix_en) begin
        req_x    <= col;
        req_y    <= row;
        s0.active <= active;
        s0.hs     <= hs;
        s0.vs     <= vs;
        s0.first  <= first;
      end
    end
  end

  // stage 1: flags wait while the layers answer
  always_ff @(posedge clk) begin
    if (reset)
      s1 <= '0;
    else
      s1 <= s0;
  end

  // stage 2: merged colour and sync outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_color  <= COLOR_BLACK;
      pixel_active <= 1'b0;
      hsync_n      <= 1'b1;
      vsync_n      <= 1'b1;
      frame_start  <= 1'b0;
    end else begin
      pixel_color  <= merge(s1.active,
                            layer.cursor_color,
                            layer.canvas_color);
      pixel_active <= s1.active;
      hsync_n      <= ~s1.hs;
      vsync_n      <= ~s1.vs;
      frame_start  <= s1.first & s1.strobe;
    end
  end

endmodule

// File: tb/tb_raster_compositor.sv
// Directed bench for raster_compositor on a
// 12x8 raster with registered layer models.
module tb_raster_compositor;
  import raster_compositor_pkg::*;

  localparam int HT = 12;
  localparam int VT = 8;
  localparam int FR = HT * VT;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_en;
  logic [3:0] pixel_color;
  logic       pixel_active;
  logic       hsync_n;
  logic       vsync_n;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  logic [3:0] cursor_mem [4][8];
  logic [3:0] canvas_mem [4][8];

  always #5 clk = ~clk;

  raster_compositor_if #(.XW(3), .YW(2)) lif ();

  raster_compositor #(
    .WIDTH   (8),
    .HEIGHT  (4),
    .H_FRONT (1),
    .H_SYNC  (2),
    .H_BACK  (1),
    .V_FRONT (1),
    .V_SYNC  (2),
    .V_BACK  (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_en       (pix_en),
    .layer        (lif.master),
    .pixel_color  (pixel_color),
    .pixel_active (pixel_active),
    .hsync_n      (hsync_n),
    .vsync_n      (vsync_n),
    .frame_start  (frame_start)
  );

  always @(posedge clk) begin
    lif.cursor_color <= cursor_mem[lif.request_y][lif.request_x];
    lif.canvas_color <= canvas_mem[lif.request_y][lif.request_x];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int hpos(int n);
    return n % HT;
  endfunction

  function automatic int vpos(int n);
    return (n / HT) % VT;
  endfunction

  function automatic logic vis(int n);
    return hpos(n) < 8 && vpos(n) < 4;
  endfunction

  // pixels from the second frame on see the edited layers
  function automatic logic [3:0] exp_color(int n);
    if (!vis(n)) return COLOR_BLACK;
    if (n >= FR && hpos(n) == 3 && vpos(n) == 2)
      return COLOR_RED;
    if (n >= FR && hpos(n) == 5 && vpos(n) == 1)
      return COLOR_BLACK;
    return COLOR_BLUE;
  endfunction

  task automatic check_req(input int n);
    logic [7:0] ex;
    logic [7:0] ey;
    ex = vis(n) ? 8'(hpos(n)) : 8'd0;
    ey = vis(n) ? 8'(vpos(n)) : 8'd0;
    check($sformatf("req_x[%0d]", n), 8'(lif.request_x), ex);
    check($sformatf("req_y[%0d]", n), 8'(lif.request_y), ey);
  endtask

  task automatic check_out(input int n, input logic fs_ok);
    logic h_lo;
    logic v_lo;
    logic fs;
    h_lo = hpos(n) == 9 || hpos(n) == 10;
    v_lo = vpos(n) == 5 || vpos(n) == 6;
    fs = fs_ok && hpos(n) == 0 && vpos(n) == 0;
    check($sformatf("color[%0d]", n), 8'(pixel_color), 8'(exp_color(n)));
    check($sformatf("active[%0d]", n), 8'(pixel_active), 8'(vis(n)));
    check($sformatf("hsync_n[%0d]", n), 8'(hsync_n), 8'(!h_lo));
    check($sformatf("vsync_n[%0d]", n), 8'(vsync_n), 8'(!v_lo));
    check($sformatf("frame_start[%0d]", n), 8'(frame_start), 8'(fs));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_color"}, 8'(pixel_color), 8'(COLOR_BLACK));
    check({tag, "_active"}, 8'(pixel_active), 8'd0);
    check({tag, "_hsync_n"}, 8'(hsync_n), 8'd1);
    check({tag, "_vsync_n"}, 8'(vsync_n), 8'd1);
    check({tag, "_fs"}, 8'(frame_start), 8'd0);
    check({tag, "_req_x"}, 8'(lif.request_x), 8'd0);
    check({tag, "_req_y"}, 8'(lif.request_y), 8'd0);
  endtask

  initial begin
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) begin
        cursor_mem[y][x] = COLOR_NONE;
        canvas_mem[y][x] = COLOR_BLUE;
      end

    // reset held three clocks with strobes running
    reset  = 1'b1;
    pix_en = 1'b1;
    repeat (3) tick();
    check_reset("reset");

    // free-running raster, two full frames
    reset = 1'b0;
    tick();
    tick();
    tick();
    for (int k = 0; k < 2 * FR; k++) begin
      if (k > 0) tick();
      check_out(k, 1'b1);
      check_req(k + 2);
      if (k == FR) begin
        cursor_mem[2][3] = COLOR_RED;
        canvas_mem[1][5] = COLOR_NONE;
      end
    end

    // stall: pipeline drains to the last issued pixel
    pix_en = 1'b0;
    repeat (3) tick();
    check_out(2 * FR + 1, 1'b0);

    // one strobe every third clock up to request (6,2)
    for (int j = 0; j <= 28; j++) begin
      int p;
      p = 2 * FR + 2 + j;
      pix_en = 1'b1;
      tick();
      pix_en = 1'b0;
      check_req(p);
      check_out(p - 1, 1'b0);
      if (j == 28) break;
      tick();
      check_out(p - 1, 1'b0);
      tick();
      check_out(p, 1'b1);
    end

    // reset mid-frame at (6,2)
    reset  = 1'b1;
    pix_en = 1'b1;
    tick();
    tick();
    check_reset("midreset");
    reset  = 1'b0;
    pix_en = 1'b0;
    tick();
    check_reset("released");

    // first strobe after release restarts the frame
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    check_req(FR);
    check("restart_fs_0", 8'(frame_start), 8'd0);
    tick();
    check("restart_fs_1", 8'(frame_start), 8'd0);
    tick();
    check_out(FR, 1'b1);
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    check_req(FR + 1);
    check_out(FR, 1'b0);
    tick();
    tick();
    check_out(FR + 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
